// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmitter and receiver.
//   - register indices on the peripheral register bus
//   - CTRL / STATUS bit positions
//   - serial FSM state encoding (the receiver reuses the same indices)
//   - parity helper
package uart_pkg;

   localparam logic [2:0] REG_CTRL   = 3'd0;
   localparam logic [2:0] REG_STATUS = 3'd1;
   localparam logic [2:0] REG_TXDATA = 3'd2;
   localparam logic [2:0] REG_DIV    = 3'd3;

   localparam int unsigned CTRL_EN      = 0;
   localparam int unsigned CTRL_PAR_EN  = 1;
   localparam int unsigned CTRL_PAR_ODD = 2;

   localparam int unsigned STAT_BUSY    = 0;
   localparam int unsigned STAT_FULL    = 1;
   localparam int unsigned STAT_EMPTY   = 2;
   localparam int unsigned STAT_OVF     = 3;
   localparam int unsigned STAT_CNT_LSB = 4;

   // PARITY sits after the four base states so the base encoding stays stable
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_STOP   = 3'd3,
      ST_PARITY = 3'd4
   } uart_state_t;

   // even: bit makes the total count of ones even; odd: makes it odd
   function automatic logic parity_bit(input logic [7:0] data, input logic odd);
      return odd ? ~^data : ^data;
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous byte FIFO for the UART transmitter.
//   clk, rst       : clock, synchronous active-high reset (flushes contents)
//   push/push_data : write strobe and byte; accepted when not full, or when
//                    a pop happens on the same edge
//   pop            : advance the read pointer (ignored when empty)
//   pop_data       : head entry, read from the registered read pointer
//   full/empty     : occupancy flags
//   count          : number of stored entries (0..DEPTH)
module uart_tx_fifo #(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [7:0]               push_data,
   input  logic                     pop,
   output logic [7:0]               pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] cnt;
   logic          do_push;
   logic          do_pop;

   assign full     = (cnt == CW'(DEPTH));
   assign empty    = (cnt == '0);
   assign count    = cnt;
   assign pop_data = mem[rd_ptr];

   // a pop on the same edge frees the slot the push needs
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_core.sv
// uart_tx_core: register-mapped UART transmitter (8N1, LSB first).
//   clk     : rising-edge clock
//   rst     : synchronous active-high reset
//   we      : register write strobe
//   reg_num : register index (0 CTRL, 1 STATUS, 2 TXDATA, 3 DIV, 4-7 unused)
//   wd      : write data
//   rd      : read data for reg_num (combinational)
//   tx      : serial output, registered, idles high
//   busy    : frame in progress or FIFO non-empty
// Build option: define UART_TX_PARITY_EN to add CTRL.PAR_EN / CTRL.PAR_ODD
// and an optional parity bit between the data bits and the stop bit.
module uart_tx_core
   import uart_pkg::*;
#(
   parameter int unsigned         FIFO_DEPTH  = 4,
   parameter int unsigned         DIV_W       = 16,
   parameter logic [DIV_W-1:0]    DEFAULT_DIV = DIV_W'(15)
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        we,
   input  logic [2:0]  reg_num,
   input  logic [31:0] wd,
   output logic [31:0] rd,
   output logic        tx,
   output logic        busy
);

   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

   // register file
   logic             ctrl_en;
   logic [DIV_W-1:0] div_reg;
   logic             ovf;
`ifdef UART_TX_PARITY_EN
   logic             ctrl_par_en;
   logic             ctrl_par_odd;
`endif

   // FIFO interface
   logic          fifo_push;
   logic          fifo_pop;
   logic [7:0]    fifo_rd;
   logic          fifo_full;
   logic          fifo_empty;
   logic [CW-1:0] fifo_count;
   logic [4:0]    cnt_ext;
   logic [3:0]    cnt4;

   // serialiser
   uart_state_t      state;
   logic [7:0]       shift;
   logic [DIV_W-1:0] bit_cnt;
   logic [DIV_W-1:0] div_lat;
   logic [2:0]       bit_idx;
`ifdef UART_TX_PARITY_EN
   logic             par_en_lat;
   logic             par_lat;
`endif

   logic wr_ctrl;
   logic wr_status;
   logic wr_div;
   logic unused_wd;

   assign wr_ctrl   = we && (reg_num == REG_CTRL);
   assign wr_status = we && (reg_num == REG_STATUS);
   assign wr_div    = we && (reg_num == REG_DIV);
   assign fifo_push = we && (reg_num == REG_TXDATA);
   assign unused_wd = ^wd;

   assign fifo_pop = (state == ST_IDLE) && ctrl_en && !fifo_empty;
   assign busy     = (state != ST_IDLE) || !fifo_empty;

   // a 16-deep FIFO holds 16 entries but the field is 4 bits: saturate at 15
   assign cnt_ext = 5'(fifo_count);
   assign cnt4    = cnt_ext[4] ? 4'hF : cnt_ext[3:0];

   uart_tx_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (fifo_push),
      .push_data (wd[7:0]),
      .pop       (fifo_pop),
      .pop_data  (fifo_rd),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         ctrl_en <= 1'b0;
         div_reg <= DEFAULT_DIV;
         ovf     <= 1'b0;
`ifdef UART_TX_PARITY_EN
         ctrl_par_en  <= 1'b0;
         ctrl_par_odd <= 1'b0;
`endif
      end else begin
         if (wr_ctrl) begin
            ctrl_en <= wd[CTRL_EN];
`ifdef UART_TX_PARITY_EN
            ctrl_par_en  <= wd[CTRL_PAR_EN];
            ctrl_par_odd <= wd[CTRL_PAR_ODD];
`endif
         end
         if (wr_div) begin
            div_reg <= wd[DIV_W-1:0];
         end
         // a push into a full FIFO is only dropped when no pop frees a slot
         if (fifo_push && fifo_full && !fifo_pop) begin
            ovf <= 1'b1;
         end else if (wr_status && wd[STAT_OVF]) begin
            ovf <= 1'b0;
         end
      end
   end

   // Every state counts bit_cnt down from the divisor latched at frame start,
   // so a DIV write mid-frame only takes effect on the next frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         tx      <= 1'b1;
         shift   <= '0;
         bit_cnt <= '0;
         div_lat <= '0;
         bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
         par_en_lat <= 1'b0;
         par_lat    <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               tx <= 1'b1;
               if (fifo_pop) begin
                  shift   <= fifo_rd;
                  div_lat <= div_reg;
                  bit_cnt <= div_reg;
                  bit_idx <= '0;
                  tx      <= 1'b0;
                  state   <= ST_START;
`ifdef UART_TX_PARITY_EN
                  par_en_lat <= ctrl_par_en;
                  par_lat    <= parity_bit(fifo_rd, ctrl_par_odd);
`endif
               end
            end
            ST_START: begin
               if (bit_cnt == '0) begin
                  bit_cnt <= div_lat;
                  tx      <= shift[0];
                  shift   <= {1'b0, shift[7:1]};
                  state   <= ST_DATA;
               end else begin
                  bit_cnt <= bit_cnt - DIV_W'(1);
               end
            end
            ST_DATA: begin
               if (bit_cnt == '0) begin
                  bit_cnt <= div_lat;
                  if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                     if (par_en_lat) begin
                        tx    <= par_lat;
                        state <= ST_PARITY;
                     end else begin
                        tx    <= 1'b1;
                        state <= ST_STOP;
                     end
`else
                     tx    <= 1'b1;
                     state <= ST_STOP;
`endif
                  end else begin
                     tx      <= shift[0];
                     shift   <= {1'b0, shift[7:1]};
                     bit_idx <= bit_idx + 3'd1;
                  end
               end else begin
                  bit_cnt <= bit_cnt - DIV_W'(1);
               end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
               if (bit_cnt == '0) begin
                  bit_cnt <= div_lat;
                  tx      <= 1'b1;
                  state   <= ST_STOP;
               end else begin
                  bit_cnt <= bit_cnt - DIV_W'(1);
               end
            end
`endif
            ST_STOP: begin
               if (bit_cnt == '0) begin
                  state <= ST_IDLE;
               end else begin
                  bit_cnt <= bit_cnt - DIV_W'(1);
               end
            end
            default: begin
               state <= ST_IDLE;
               tx    <= 1'b1;
            end
         endcase
      end
   end

   always_comb begin
      rd = '0;
      case (reg_num)
         REG_CTRL: begin
            rd[CTRL_EN] = ctrl_en;
`ifdef UART_TX_PARITY_EN
            rd[CTRL_PAR_EN]  = ctrl_par_en;
            rd[CTRL_PAR_ODD] = ctrl_par_odd;
`endif
         end
         REG_STATUS: begin
            rd[STAT_BUSY]           = busy;
            rd[STAT_FULL]           = fifo_full;
            rd[STAT_EMPTY]          = fifo_empty;
            rd[STAT_OVF]            = ovf;
            rd[STAT_CNT_LSB +: 4]   = cnt4;
         end
         REG_DIV: begin
            rd = 32'(div_reg);
         end
         default: begin
            rd = '0;
         end
      endcase
   end

endmodule
